// File: rtl/hht_dot_sequencer_if.sv
// Read-port pair and result handshake between the dot-product sequencer and its environment.
interface hht_dot_sequencer_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic [AW-1:0]   addr1;
    logic [AW-1:0]   addr2;
    logic [DW-1:0]   dataIn1;
    logic [DW-1:0]   dataIn2;
    logic            rd_en;
    logic [2*DW-1:0] res_data;
    logic [15:0]     res_idx;
    logic            res_valid;
    logic            res_ready;

    modport master (
        output addr1, addr2, rd_en, res_data, res_idx, res_valid,
        input  dataIn1, dataIn2, res_ready
    );

    modport slave (
        input  addr1, addr2, rd_en, res_data, res_idx, res_valid,
        output dataIn1, dataIn2, res_ready
    );
endinterface

// File: rtl/hht_dot_sequencer.sv
// Streams a column against a repeating v vector, emitting one dot product per vsize-word segment.
module hht_dot_sequencer #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [AW-1:0]         wdata_col_base,
    input  logic [AW-1:0]         v_values_base,
    input  logic [31:0]           csize,
    input  logic [31:0]           vsize,
    output logic                  busy,
    output logic                  done,
    hht_dot_sequencer_if.master   bus
);
    localparam int unsigned PW = 2 * DW;

    typedef enum logic [1:0] {StIdle, StFetch, StOut, StFin} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] col_base_q, col_base_d, v_base_q, v_base_d;
    logic [31:0]   csize_q, csize_d, vsize_q, vsize_d;
    logic [31:0]   col_ptr_q, col_ptr_d, v_ptr_q, v_ptr_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [15:0]   res_idx_q, res_idx_d;
    logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;

    logic [AW-1:0] fetch_addr1, fetch_addr2;
    logic [PW-1:0] prod;
    logic          seg_end;

    assign fetch_addr1 = col_base_q + AW'(col_ptr_q);
    assign fetch_addr2 = v_base_q + AW'(v_ptr_q);
    assign prod        = PW'(bus.dataIn1) * PW'(bus.dataIn2);
    assign seg_end     = (v_ptr_q == vsize_q - 32'd1) || (col_ptr_q == csize_q - 32'd1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (csize == 32'd0 || vsize == 32'd0) ? StFin : StFetch;
                end
            end
            StFetch: begin
                if (seg_end) state_d = StOut;
            end
            StOut: begin
                if (bus.res_ready) state_d = (col_ptr_q < csize_q) ? StFetch : StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q != StIdle);
        done          = (state_q == StFin);
        bus.rd_en     = (state_q == StFetch);
        bus.res_valid = (state_q == StOut);
        // Addresses hold the last fetched location whenever no read is in flight.
        bus.addr1     = (state_q == StFetch) ? fetch_addr1 : addr1_q;
        bus.addr2     = (state_q == StFetch) ? fetch_addr2 : addr2_q;
        bus.res_data  = acc_q;
        bus.res_idx   = res_idx_q;
    end

    always_comb begin
        col_base_d = col_base_q;
        v_base_d   = v_base_q;
        csize_d    = csize_q;
        vsize_d    = vsize_q;
        col_ptr_d  = col_ptr_q;
        v_ptr_d    = v_ptr_q;
        acc_d      = acc_q;
        res_idx_d  = res_idx_q;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    col_base_d = wdata_col_base;
                    v_base_d   = v_values_base;
                    csize_d    = csize;
                    vsize_d    = vsize;
                    col_ptr_d  = '0;
                    v_ptr_d    = '0;
                    acc_d      = '0;
                    res_idx_d  = '0;
                end
            end
            StFetch: begin
                acc_d     = acc_q + prod;
                col_ptr_d = col_ptr_q + 32'd1;
                v_ptr_d   = v_ptr_q + 32'd1;
                addr1_d   = fetch_addr1;
                addr2_d   = fetch_addr2;
            end
            StOut: begin
                if (bus.res_ready) begin
                    acc_d     = '0;
                    v_ptr_d   = '0;
                    res_idx_d = res_idx_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col_base_q <= '0;
            v_base_q   <= '0;
            csize_q    <= '0;
            vsize_q    <= '0;
            col_ptr_q  <= '0;
            v_ptr_q    <= '0;
            acc_q      <= '0;
            res_idx_q  <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
        end else begin
            col_base_q <= col_base_d;
            v_base_q   <= v_base_d;
            csize_q    <= csize_d;
            vsize_q    <= vsize_d;
            col_ptr_q  <= col_ptr_d;
            v_ptr_q    <= v_ptr_d;
            acc_q      <= acc_d;
            res_idx_q  <= res_idx_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
        end
    end
endmodule

// File: tb/tb_hht_dot_sequencer.sv
// Bench for hht_dot_sequencer: directed vector table, corner sequences and randomized jobs vs. a model.
module tb_hht_dot_sequencer;
    logic        Clk;
    logic        Rst;
    logic        start;
    logic [31:0] wdata_col_base, v_values_base, csize, vsize;
    logic        busy, done;
    logic        res_ready;

    logic [31:0] cmem [256];
    logic [31:0] vmem [256];

    hht_dot_sequencer_if #(.DW(32), .AW(32)) bif ();

    assign bif.dataIn1   = cmem[bif.addr1[7:0]];
    assign bif.dataIn2   = vmem[bif.addr2[7:0]];
    assign bif.res_ready = res_ready;

    hht_dot_sequencer #(.DW(32), .AW(32)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .start          (start),
        .wdata_col_base (wdata_col_base),
        .v_values_base  (v_values_base),
        .csize          (csize),
        .vsize          (vsize),
        .busy           (busy),
        .done           (done),
        .bus            (bif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endfunction

    // Monitor: results, read cycles, done pulses and stall stability, all sampled on negedge.
    logic [63:0] got_data[$];
    logic [15:0] got_idx[$];
    int          rd_cnt, done_cnt;
    bit          stall_mode;
    bit          hold_ok;
    logic [63:0] snap_data;
    logic [15:0] snap_idx;
    logic [31:0] snap_a1, snap_a2;

    initial begin
        hold_ok = 0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                if (bif.rd_en) rd_cnt++;
                if (done) done_cnt++;
                if (bif.res_valid) begin
                    check("rd_en_in_out", bif.rd_en, 0);
                    if (hold_ok) begin
                        check("stall_data", bif.res_data, snap_data);
                        check("stall_idx", bif.res_idx, snap_idx);
                        check("stall_addr1", bif.addr1, snap_a1);
                        check("stall_addr2", bif.addr2, snap_a2);
                    end
                    snap_data = bif.res_data;
                    snap_idx  = bif.res_idx;
                    snap_a1   = bif.addr1;
                    snap_a2   = bif.addr2;
                    hold_ok   = !res_ready;
                    if (res_ready) begin
                        got_data.push_back(bif.res_data);
                        got_idx.push_back(bif.res_idx);
                    end
                end else begin
                    hold_ok = 0;
                end
            end
        end
    end

    // Ready driver: in stall mode hold ready low for 5 cycles of every result.
    int scnt;
    initial begin
        res_ready = 1'b1;
        scnt = 0;
        forever begin
            @(posedge Clk);
            #1;
            if (!stall_mode) res_ready = 1'b1;
            else if (!bif.res_valid) begin res_ready = 1'b0; scnt = 0; end
            else if (scnt < 5) begin res_ready = 1'b0; scnt++; end
            else res_ready = 1'b1;
        end
    end

    // Reference: word i of the column pairs with v word i mod vsize; a segment closes every
    // vsize words or at the last column word.
    logic [63:0] exp_q[$];
    function automatic void build_exp(logic [31:0] cb, logic [31:0] vb, logic [31:0] cs,
                                      logic [31:0] vs);
        logic [63:0] acc, x, y;
        logic [31:0] a1, a2, j;
        exp_q.delete();
        acc = 0;
        if (cs != 0 && vs != 0) begin
            for (int unsigned i = 0; i < cs; i++) begin
                j   = i % vs;
                a1  = cb + i;
                a2  = vb + j;
                x   = {32'd0, cmem[a1[7:0]]};
                y   = {32'd0, vmem[a2[7:0]]};
                acc = acc + x * y;
                if (j == vs - 1 || i == cs - 1) begin
                    exp_q.push_back(acc);
                    acc = 0;
                end
            end
        end
    endfunction

    task automatic run_job(input logic [31:0] cb, input logic [31:0] vb, input logic [31:0] cs,
                           input logic [31:0] vs, input bit stall, input bit poke);
        build_exp(cb, vb, cs, vs);
        got_data.delete();
        got_idx.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        stall_mode = stall;
        @(posedge Clk); #1;
        wdata_col_base = cb; v_values_base = vb; csize = cs; vsize = vs; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        if (poke) begin
            repeat (3) @(posedge Clk);
            #1;
            check("busy_at_poke", busy, 1);
            start = 1'b1; wdata_col_base = $urandom; v_values_base = $urandom;
            csize = 32'd7; vsize = 32'd2;
            @(posedge Clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge Clk);
        repeat (3) @(posedge Clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("rd_cycles", rd_cnt, (cs != 0 && vs != 0) ? cs : 0);
        check("n_results", got_data.size(), exp_q.size());
        for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
            check($sformatf("res_data[%0d]", i), got_data[i], exp_q[i]);
            check($sformatf("res_idx[%0d]", i), got_idx[i], i);
        end
        stall_mode = 0;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_addr1"}, bif.addr1, 0);
        check({tag, "_addr2"}, bif.addr2, 0);
        check({tag, "_rd_en"}, bif.rd_en, 0);
        check({tag, "_res_valid"}, bif.res_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_res_data"}, bif.res_data, 0);
        check({tag, "_res_idx"}, bif.res_idx, 0);
    endtask

    task automatic zero_job(input logic [31:0] cs, input logic [31:0] vs);
        @(posedge Clk); #1;
        wdata_col_base = 180; v_values_base = 2; csize = cs; vsize = vs; start = 1'b1;
        @(negedge Clk);
        check("zero_done_early", done, 0);
        @(posedge Clk); #1;
        start = 1'b0;
        @(negedge Clk);
        check("zero_done_pulse", done, 1);
        check("zero_res_valid", bif.res_valid, 0);
        check("zero_rd_en", bif.rd_en, 0);
        @(negedge Clk);
        check("zero_done_once", done, 0);
    endtask

    typedef struct {
        logic [31:0] cb, vb, cs, vs;
        bit          stall;
        int          nres;
        logic [63:0] res0;
    } vec_t;

    vec_t vt[7];
    logic [31:0] col_init[18] = '{0, 5, 7, 10, 6, 9, 2, 0, 6, 15, 0, 10, 9, 4, 6, 2, 10, 11};
    logic [31:0] col_tail[6]  = '{15, 6, 1, 6, 1, 15};
    logic [31:0] v_init[9]    = '{55, 1, 0, 97, 10, 67, 66, 54, 3};

    initial begin
        vt[0] = '{cb: 180, vb: 2, cs: 51, vs: 9, stall: 0, nres: 6,  res0: 1788};
        vt[1] = '{cb: 180, vb: 2, cs: 51, vs: 9, stall: 1, nres: 6,  res0: 1788};
        vt[2] = '{cb: 180, vb: 2, cs: 4,  vs: 9, stall: 0, nres: 1,  res0: 975};
        vt[3] = '{cb: 180, vb: 2, cs: 0,  vs: 9, stall: 0, nres: 0,  res0: 0};
        vt[4] = '{cb: 180, vb: 2, cs: 9,  vs: 0, stall: 0, nres: 0,  res0: 0};
        vt[5] = '{cb: 180, vb: 2, cs: 9,  vs: 9, stall: 1, nres: 1,  res0: 1788};
        vt[6] = '{cb: 181, vb: 2, cs: 3,  vs: 1, stall: 0, nres: 3,  res0: 275};

        for (int i = 0; i < 256; i++) begin cmem[i] = 0; vmem[i] = 0; end
        for (int i = 0; i < 18; i++) cmem[180 + i] = col_init[i];
        for (int i = 198; i < 225; i++) cmem[i] = (i * 7 + 3) % 16;
        for (int i = 0; i < 6; i++) cmem[225 + i] = col_tail[i];
        for (int i = 0; i < 9; i++) vmem[2 + i] = v_init[i];

        stall_mode = 0; rd_cnt = 0; done_cnt = 0;
        start = 0; wdata_col_base = 0; v_values_base = 0; csize = 0; vsize = 0;
        Rst = 1'b0;
        #13;
        check_zero("reset");
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_job(vt[i].cb, vt[i].vb, vt[i].cs, vt[i].vs, vt[i].stall, 1'b0);
            check($sformatf("vec%0d_nres", i), got_data.size(), vt[i].nres);
            if (got_data.size() > 0) check($sformatf("vec%0d_res0", i), got_data[0], vt[i].res0);
        end

        // Start pulsed and inputs changed mid-job must not disturb the latched job.
        run_job(180, 2, 51, 9, 1'b0, 1'b1);
        if (got_data.size() == 6) begin
            check("poke_res0", got_data[0], 1788);
            check("poke_res1", got_data[1], 2845);
            check("poke_res5", got_data[5], 2428);
        end

        zero_job(0, 9);
        zero_job(9, 0);

        // Reset during segment 1 fetch clears everything at once and emits nothing afterwards.
        @(posedge Clk); #1;
        wdata_col_base = 180; v_values_base = 2; csize = 51; vsize = 9; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        begin
            bit found;
            found = 0;
            for (int k = 0; k < 200 && !found; k++) begin
                @(negedge Clk);
                if (bif.res_idx == 16'd1 && bif.rd_en) found = 1;
            end
            check("abort_reached_seg1", found, 1);
        end
        #2;
        Rst = 1'b0;
        #1;
        check_zero("abort");
        got_data.delete();
        got_idx.delete();
        @(negedge Clk);
        Rst = 1'b1;
        repeat (20) @(negedge Clk);
        check("abort_busy", busy, 0);
        check("abort_no_results", got_data.size(), 0);
        run_job(180, 2, 51, 9, 1'b0, 1'b0);
        if (got_data.size() > 0) check("after_abort_res0", got_data[0], 1788);

        // Randomized jobs, including addresses wrapping past 2^32 and full-width data.
        for (int i = 0; i < 256; i++) begin cmem[i] = $urandom; vmem[i] = $urandom; end
        for (int r = 0; r < 16; r++) begin
            logic [31:0] cb, vb;
            cb = (r % 3 == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            vb = (r % 4 == 1) ? 32'hFFFF_FFFA : $urandom;
            run_job(cb, vb, $urandom_range(0, 40), $urandom_range(0, 12),
                    bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hht_dot_sequencer.md
HHT_DOT_SEQUENCER -- requirements
Module: hht_dot_sequencer

Interface
REQ-001 Parameter: DW, 32, data width of dataIn1/dataIn2.
REQ-002 Parameter: AW, 32, address width of addr1/addr2.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a job; sampled in IDLE only.
REQ-006 wdata_col_base  input  AW  base address of column data (port 1).
REQ-007 v_values_base  input  AW  base address of v vector (port 2).
REQ-008 csize  input  32  total column words to process.
REQ-009 vsize  input  32  v vector length, equal to segment length.
REQ-010 addr1  output  AW  column read address.
REQ-011 addr2  output  AW  v read address.
REQ-012 dataIn1  input  DW  column read data; combinational, valid in the same cycle as addr1.
REQ-013 dataIn2  input  DW  v read data; combinational, valid in the same cycle as addr2.
REQ-014 rd_en  output  1  high in every cycle where addr1/addr2 carry a consumed read.
REQ-015 res_data  output  2*DW  dot product of the current segment.
REQ-016 res_idx  output  16  segment index of res_data, starting at 0.
REQ-017 res_valid  output  1  result handshake valid.
REQ-018 res_ready  input  1  result handshake ready.
REQ-019 busy  output  1  high in every state other than IDLE.
REQ-020 done  output  1  one-cycle pulse at job end.

Function
REQ-021 States: IDLE, FETCH, OUT, FIN. No other states.
- IDLE -> FETCH on start with csize!=0 and vsize!=0.
- IDLE -> FIN on start with csize==0 or vsize==0.
REQ-022 On the accepting start edge, latch both bases, csize and vsize. Clear col_ptr, v_ptr, acc and res_idx. Later input changes are ignored until the next IDLE.
REQ-023 FETCH, per cycle:
- rd_en=1, addr1=col_base+col_ptr, addr2=v_base+v_ptr.
- Sample acc <= acc + dataIn1*dataIn2 at the edge; full 2*DW product, sum wraps mod 2^(2*DW).
- Then increment col_ptr and v_ptr.
REQ-024 Segment end is v_ptr==vsize-1 or col_ptr==csize-1. After that fetch, go to OUT, with res_data equal to the accumulated sum including the last product.
REQ-025 Latency: a segment of n words takes n FETCH cycles; res_valid rises in the cycle after the last fetch.
REQ-026 OUT:
- res_valid=1, rd_en=0; res_data and res_idx held stable.
- When res_valid and res_ready are both high at an edge: clear acc, reset v_ptr to 0, increment res_idx.
- Next state is FETCH if col_ptr<csize, otherwise FIN.
REQ-027 Last segment is partial when csize is not a multiple of vsize. It uses the remaining words; v_ptr restarts at 0 for every segment.
REQ-028 FIN asserts done=1 for exactly one cycle, then goes to IDLE.
REQ-029 start while busy=1 is ignored and has no side effect.
REQ-030 Addresses wrap modulo 2^AW.
REQ-031 Outside FETCH:
- addr1 and addr2 hold their last value.
- rd_en=0.

Reset
REQ-032 Rst low forces these values immediately, regardless of state, including mid-FETCH and mid-OUT:
- state=IDLE;
- addr1=0, addr2=0;
- rd_en=0, res_valid=0, busy=0, done=0;
- res_data=0, res_idx=0;
- acc and all pointers=0.
REQ-033 After Rst rises, the block stays in IDLE until a new start; no result from an aborted job is emitted.

Verification
REQ-034 Column memory (base 180): 0,5,7,10,6,9,2,0,6,15,0,10,9,4,6,2,10,11 ... ending with 225..230 = 15,6,1,6,1,15. v memory (base 2): 55,1,0,97,10,67,66,54,3. Job: csize=51, vsize=9, res_ready=1 -> six results with res_idx 0..5. res_idx0=1788, res_idx1=2845, res_idx5=2428 (6-word partial segment). done pulses once.
REQ-035 Same job with res_ready low for 5 cycles at each OUT -> identical results; rd_en=0 and res_data stable while stalled; no address advance.
REQ-036 start with csize=0, then start with vsize=0 -> each gives done one cycle after start; res_valid never asserted; rd_en never high.
REQ-037 csize=4, vsize=9, bases 180/2 -> one result of 5+0+970 plus 0*55 = 975 after 4 FETCH cycles, res_idx=0.
REQ-038 Rst low during segment 1 FETCH -> all outputs 0 asynchronously. A new start with the REQ-034 job reproduces res_idx0=1788.
REQ-039 start pulsed while busy -> ignored; latched bases unchanged; results match REQ-034.
